// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and width helpers for the FIFO write-port arbiter
// Contents: state_t (IDLE/BURST), req_w() index width, cnt_w() beat counter width.

package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Index width for NUM_REQ requesters (REQ_W); never zero so ports stay legal.
    function automatic int req_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Beat counter width (CNT_W); must hold MAX_BURST itself, since the counter
    // still increments on the final beat of a full-length burst.
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer-side and FIFO write-port bundle of the arbiter
// Signals: req_valid/req_last/req_data/req_ready (producers), Full/W_En/W_Data (FIFO),
//          grant_id/busy (status). master = arbiter side, slave = producers + FIFO side.

interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 32
);
    import fifo_wr_arbiter_pkg::*;

    localparam int REQ_W = req_w(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*DATAWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         Full;
    logic                         W_En;
    logic [DATAWIDTH-1:0]         W_Data;
    logic [REQ_W-1:0]             grant_id;
    logic                         busy;

    modport master (
        input  req_valid, req_last, req_data, Full,
        output req_ready, W_En, W_Data, grant_id, busy
    );

    modport slave (
        output req_valid, req_last, req_data, Full,
        input  req_ready, W_En, W_Data, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational cyclic priority search
// Ports: req (N request bits), ptr (search start, < N), winner (first set index at or
//        after ptr, wrapping), any_req (at least one request set).

module fifo_wr_arbiter_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic [W:0]   sum;
    logic [W-1:0] cur;

    // Walk ptr, ptr+1, ... modulo N; the extra sum bit lets the wrap be a single
    // subtract, so N need not be a power of two and cur never reaches N.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        sum     = '0;
        cur     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (W+1)'(i);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            cur = sum[W-1:0];
            if (!any_req && req[cur]) begin
                any_req = 1'b1;
                winner  = cur;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst round-robin arbiter in front of the async FIFO write port
// Ports: wclk (write clock), wrst (async active-high reset), bus (fifo_wr_arbiter_if.master:
//        producer valid/last/data/ready, FIFO Full/W_En/W_Data, grant_id, busy).

module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    fifo_wr_arbiter_if.master     bus
);

    localparam int REQ_W = req_w(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);
    localparam logic [REQ_W-1:0] LAST_IDX  = REQ_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t               state_q, state_d;
    logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     beat_q, beat_d;
    logic [REQ_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   own_sel;
    logic [DATAWIDTH-1:0] own_data;
    logic                 own_valid;
    logic                 own_last;
    logic                 busy;
    logic                 beat;

    fifo_wr_arbiter_rr_pick #(
        .N (NUM_REQ),
        .W (REQ_W)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Owner mux as a one-hot select so no variable part-select is needed.
    always_comb begin
        own_sel  = '0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == REQ_W'(i)) begin
                own_sel[i] = 1'b1;
                own_data   = bus.req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign own_valid = |(bus.req_valid & own_sel);
    assign own_last  = |(bus.req_last & own_sel);
    assign busy      = (state_q == BURST);
    assign beat      = busy & own_valid & ~bus.Full;

    // Outputs derive from registered state only, so the async reset clears them at once.
    assign bus.busy      = busy;
    assign bus.grant_id  = grant_q;
    assign bus.W_En      = beat;
    assign bus.W_Data    = busy ? own_data : '0;
    assign bus.req_ready = (busy && !bus.Full) ? own_sel : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat) begin
                    beat_d = beat_q + 1'b1;
                end
                // A dropped owner ends the burst even while Full stalls it;
                // Full alone only freezes the grant and the count.
                if (!own_valid || (beat && (own_last || beat_q == LAST_BEAT))) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
// Instances: u_a (NUM_REQ=4, MAX_BURST=8) and u_b (NUM_REQ=3, MAX_BURST=1) on one wclk/wrst.

module tb_fifo_wr_arbiter;

    logic wclk;
    logic wrst;
    int   total;
    int   bad;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATAWIDTH(32)) bus_a ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .DATAWIDTH(32)) bus_b ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATAWIDTH(32), .MAX_BURST(8)) u_a (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus_a)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATAWIDTH(32), .MAX_BURST(1)) u_b (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full check of unit A outputs; grant_id is only meaningful while busy.
    task automatic chk_a(input string tag, input logic exp_busy, input logic exp_en,
                         input int exp_g, input logic [31:0] exp_d, input logic [3:0] exp_rdy);
        chk({tag, ".busy"}, 64'(bus_a.busy), 64'(exp_busy));
        chk({tag, ".w_en"}, 64'(bus_a.W_En), 64'(exp_en));
        chk({tag, ".w_data"}, 64'(bus_a.W_Data), 64'(exp_d));
        chk({tag, ".ready"}, 64'(bus_a.req_ready), 64'(exp_rdy));
        if (exp_busy) chk({tag, ".grant"}, 64'(bus_a.grant_id), 64'(exp_g));
    endtask

    task automatic set_a(input int i, input logic [31:0] v);
        bus_a.req_data[i*32 +: 32] = v;
    endtask

    logic [31:0] w2 [3];
    int          g;
    int          nb;
    logic        fb;

    initial begin
        total = 0;
        bad   = 0;
        wrst  = 1'b1;
        bus_a.req_valid = '0; bus_a.req_last = '0; bus_a.req_data = '0; bus_a.Full = 1'b0;
        bus_b.req_valid = '0; bus_b.req_last = '0; bus_b.req_data = '0; bus_b.Full = 1'b0;
        tick();

        // Reset state
        chk_a("reset", 1'b0, 1'b0, 0, 32'h0, 4'b0000);
        chk("reset.grant_id", 64'(bus_a.grant_id), 64'd0);
        chk("reset.rr_ptr", 64'(u_a.rr_ptr_q), 64'd0);
        chk("reset.b_busy", 64'(bus_b.busy), 64'd0);
        wrst = 1'b0;

        // 1: requesters 0 and 2 held valid, no last -> 8-beat bursts alternating 0,2,0
        for (int i = 0; i < 4; i++) set_a(i, 32'hD0D0_0000 + 32'(i));
        bus_a.req_valid = 4'b0101;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k <= 8 || k == 19) g = 0; else if (k >= 10 && k <= 17) g = 2; else g = -1;
            if (g >= 0) chk_a($sformatf("t1.k%0d", k), 1'b1, 1'b1, g, 32'hD0D0_0000 + 32'(g), 4'(1 << g));
            else chk_a($sformatf("t1.k%0d", k), 1'b0, 1'b0, 0, 32'h0, 4'b0000);
        end
        bus_a.req_valid = '0;
        tick();
        chk("t1.drop_busy", 64'(bus_a.busy), 64'd0);
        chk("t1.rr_ptr", 64'(u_a.rr_ptr_q), 64'd1);

        // 2: requester 1 alone sends 3 words, last on the third
        w2[0] = 32'h1111_0001; w2[1] = 32'h1111_0002; w2[2] = 32'h1111_0003;
        set_a(1, w2[0]);
        bus_a.req_valid = 4'b0010;
        tick();
        for (int b = 0; b < 3; b++) begin
            set_a(1, w2[b]);
            bus_a.req_last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            chk_a($sformatf("t2.b%0d", b), 1'b1, 1'b1, 1, w2[b], 4'b0010);
            tick();
        end
        bus_a.req_valid = '0;
        bus_a.req_last  = '0;
        #1;
        chk("t2.busy_after", 64'(bus_a.busy), 64'd0);
        chk("t2.w_en_after", 64'(bus_a.W_En), 64'd0);
        chk("t2.rr_ptr", 64'(u_a.rr_ptr_q), 64'd2);

        // 3: requester 3 stalled by Full for 5 cycles after its 2nd beat
        nb = 0;
        set_a(3, 32'h3000_0000);
        bus_a.req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 13; c++) begin
            fb = (c >= 2 && c <= 6);
            bus_a.Full = fb;
            set_a(3, 32'h3000_0000 + 32'(nb));
            #1;
            chk_a($sformatf("t3.c%0d", c), 1'b1, !fb, 3, 32'h3000_0000 + 32'(nb), fb ? 4'b0000 : 4'b1000);
            if (!fb) nb++;
            tick();
        end
        chk("t3.beats", 64'(nb), 64'd8);
        bus_a.req_valid = '0;
        bus_a.Full = 1'b0;
        #1;
        chk("t3.busy_after", 64'(bus_a.busy), 64'd0);
        chk("t3.rr_ptr", 64'(u_a.rr_ptr_q), 64'd0);

        // 4: owner 0 drops after 4 beats; requester 1 is next
        set_a(0, 32'h4000_0000); set_a(1, 32'h4100_0000); set_a(2, 32'h4200_0000);
        bus_a.req_valid = 4'b0111;
        tick();
        for (int b = 0; b < 4; b++) begin
            set_a(0, 32'h4000_0000 + 32'(b));
            #1;
            chk_a($sformatf("t4.b%0d", b), 1'b1, 1'b1, 0, 32'h4000_0000 + 32'(b), 4'b0001);
            tick();
        end
        bus_a.req_valid = 4'b0110;
        #1;
        chk("t4.drop_w_en", 64'(bus_a.W_En), 64'd0);
        chk("t4.drop_busy", 64'(bus_a.busy), 64'd1);
        tick();
        chk("t4.idle", 64'(bus_a.busy), 64'd0);
        tick();
        chk_a("t4.next", 1'b1, 1'b1, 1, 32'h4100_0000, 4'b0010);
        bus_a.req_valid = '0;
        tick();
        chk("t4.end_busy", 64'(bus_a.busy), 64'd0);

        // 5: async reset at beat 5 of a burst from requester 0
        set_a(0, 32'h5000_0000);
        bus_a.req_valid = 4'b0001;
        tick();
        for (int b = 0; b < 4; b++) begin
            set_a(0, 32'h5000_0000 + 32'(b));
            #1;
            chk($sformatf("t5.b%0d", b), 64'(bus_a.W_En), 64'd1);
            tick();
        end
        set_a(0, 32'h5000_0004);
        #1;
        chk("t5.beat5_presented", 64'(bus_a.W_En), 64'd1);
        wrst = 1'b1;
        #1;
        chk_a("t5.in_reset", 1'b0, 1'b0, 0, 32'h0, 4'b0000);
        chk("t5.grant_zero", 64'(bus_a.grant_id), 64'd0);
        tick();
        wrst = 1'b0;
        set_a(1, 32'h5100_0000); set_a(3, 32'h5300_0000);
        bus_a.req_valid = 4'b1010;
        #1;
        chk("t5.released_idle", 64'(bus_a.busy), 64'd0);
        tick();
        chk_a("t5.first_grant", 1'b1, 1'b1, 1, 32'h5100_0000, 4'b0010);
        bus_a.req_valid = '0;
        tick();
        chk("t5.end_busy", 64'(bus_a.busy), 64'd0);

        // 6: NUM_REQ=3, MAX_BURST=1, all valid -> 0,1,2,0,1,2 one write every 2 cycles
        for (int i = 0; i < 3; i++) bus_b.req_data[i*32 +: 32] = 32'h6000_0000 + 32'(i);
        bus_b.req_valid = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("t6.k%0d.busy", k), 64'(bus_b.busy), 64'(k % 2));
            chk($sformatf("t6.k%0d.w_en", k), 64'(bus_b.W_En), 64'(k % 2));
            chk($sformatf("t6.k%0d.range", k), 64'(bus_b.grant_id < 2'd3), 64'd1);
            if (k % 2 == 1) begin
                g = ((k - 1) / 2) % 3;
                chk($sformatf("t6.k%0d.grant", k), 64'(bus_b.grant_id), 64'(g));
                chk($sformatf("t6.k%0d.data", k), 64'(bus_b.W_Data), 64'(32'h6000_0000 + 32'(g)));
            end
        end
        bus_b.req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
